timer_capture: RTL and testbench
================================

Name: timer_capture

Overview:
- Input-capture unit; reads a free-running timer count rather than producing one.
- Timestamps edges on an external asynchronous input with the 64-bit TIMER_VALUE supplied by the timer core.
- Queues timestamps in a small FIFO that software drains through register-mapped strobes.
- Raises an interrupt while captures are pending.

Parameters:
- DATA_W, 32, half-width of timestamp; timestamp is 2*DATA_W bits.
- FIFO_DEPTH_LOG2, 2, log2 of capture FIFO depth (default 4 entries).
- SYNC_STAGES, 2, flops in CAPTURE_IN synchronizer, minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset; all state clears while rst=0.
- TIMER_VALUE  input  2*DATA_W  live timer count.
- CAPTURE_IN  input  1  external asynchronous event signal.
- CAPTURE_ENABLE  input  1  arms edge detection.
- CAPTURE_EDGE_SEL  input  2  edge select: 0 none, 1 rising, 2 falling, 3 both.
- CAPTURE_POP  input  1  one-cycle strobe; discards head entry.
- CAPTURE_OVF_CLR  input  1  one-cycle strobe; clears overflow flag.
- CAPTURE_INTERRUPT_ENABLE  input  1  interrupt mask.
- CAPTURE_DATA  output  2*DATA_W  head-of-FIFO timestamp (show-ahead).
- CAPTURE_EMPTY  output  1  FIFO empty.
- CAPTURE_FULL  output  1  FIFO full.
- CAPTURE_LEVEL  output  FIFO_DEPTH_LOG2+1  entry count.
- CAPTURE_OVERFLOW  output  1  sticky; an event was dropped.
- CAPTURE_INTERRUPT  output  1  registered interrupt.

Behaviour:
- Reset values: CAPTURE_DATA=0, EMPTY=1, FULL=0, LEVEL=0, OVERFLOW=0, INTERRUPT=0.
  - Synchronizer chain and previous-level flop reset to 0.
  - A high CAPTURE_IN at release therefore reads as a rising edge once it propagates.
- Synchronizer: CAPTURE_IN passes through SYNC_STAGES flops and runs regardless of enable.
- Edge detect: compares synchronized value with its 1-cycle delayed copy.
  - event = CAPTURE_ENABLE & ((rise & SEL[0]) | (fall & SEL[1])).
- Timestamp: TIMER_VALUE on the cycle event is asserted is written to the FIFO at the next clk edge.
  - Latency from CAPTURE_IN change to FIFO write is SYNC_STAGES+1 cycles; the timestamp reflects that delay.
  - No compensation is applied.
- FIFO is a circular buffer with read/write pointers of FIFO_DEPTH_LOG2+1 bits; full/empty come from the MSB compare.
- CAPTURE_DATA:
  - Combinational read of the head entry.
  - Valid only when EMPTY=0.
  - When empty, holds the last popped or reset value.
- Pop on empty: ignored; no pointer change, no error.
- Push on full without pop: event dropped, FIFO unchanged, OVERFLOW <= 1 the following cycle.
- Push and pop in the same cycle:
  - Both are performed and LEVEL is unchanged.
  - When full, the push is accepted; no overflow.
  - When empty, the pop is ignored and the push is performed; LEVEL becomes 1.
- OVERFLOW clears only on CAPTURE_OVF_CLR. If clear and a new overflow coincide, set wins.
- CAPTURE_ENABLE deassertion stops new captures only. FIFO contents and flags are retained. No flush input exists; software pops until empty.
- CAPTURE_INTERRUPT <= CAPTURE_INTERRUPT_ENABLE & !EMPTY (registered, one cycle after the condition).
  - It is a level interrupt and stays high until the FIFO is drained or the mask is cleared.
- Both-edge mode with an input toggling faster than the sync chain: every detected transition is a separate event, at most one per cycle.
- Timer wrap (TIMER_VALUE rolling to 0) needs no special handling; software computes differences modulo 2^(2*DATA_W).

Optional Feature:
- Macro: TIMER_CAPTURE_FILTER_EN.
- Defined:
  - A glitch filter sits after the synchronizer. Local parameter FILTER_LEN=4.
  - The filtered level changes only after the synchronized input holds the new value for FILTER_LEN consecutive cycles, counted by a saturating counter that resets on any mismatch.
  - Edge detection operates on the filtered level; latency becomes SYNC_STAGES+FILTER_LEN+1.
- Undefined:
  - No filter logic; edge detection operates directly on the synchronized signal.

Decomposition:
- Shared package/header holds:
  - edge-select encodings: CAPTURE_EDGE_NONE=0, RISE=1, FALL=2, BOTH=3;
  - width macros: CAPTURE_DATA_W, CAPTURE_LEVEL_W, CAPTURE_EDGE_SEL_W, alongside the existing TIMER_* widths.
- One sub-module: timer_capture_fifo.
  - Parameterized width/depth; show-ahead.
  - Push/pop, full/empty/level.
  - Drop-on-full with an overflow pulse output.
- Synchronizer, edge detect, filter, flags and interrupt stay in timer_capture.

Test Plan:
- Reset held at rst=0 with CAPTURE_IN=0 -> all outputs at reset values; release, no toggles -> EMPTY stays 1, INTERRUPT 0.
- SEL=1, ENABLE=1, TIMER_VALUE incrementing from 100, CAPTURE_IN rises at cycle 10 -> LEVEL=1, CAPTURE_DATA = value sampled at cycle 10+SYNC_STAGES. With INTERRUPT_ENABLE=1, INTERRUPT=1 one cycle after EMPTY falls.
- SEL=3, five pulses with FIFO depth 4 and no pops -> 4 timestamps stored in order (rise, fall, rise, fall), FULL=1, OVERFLOW=1. Pop 4 times -> EMPTY=1, INTERRUPT=0, OVERFLOW still 1 until CAPTURE_OVF_CLR.
- FIFO full, event and CAPTURE_POP in the same cycle -> LEVEL stays 4, OVERFLOW stays 0, new head = old second entry.
- ENABLE=0 during edges -> no writes; SEL=0 with ENABLE=1 -> no writes; pop while empty -> LEVEL stays 0.
- With TIMER_CAPTURE_FILTER_EN: a 2-cycle pulse -> no capture; a 6-cycle pulse with SEL=3 -> exactly two captures, 6 timer counts apart.

Source files
------------

// File: rtl/timer_capture_pkg.sv
// Shared definitions for the timer input-capture unit.
//
// Contents:
//   - Timer width constants (TIMER_DATA_W, TIMER_VALUE_W).
//   - Capture width and default constants (CAPTURE_DATA_W, CAPTURE_LEVEL_W,
//     CAPTURE_EDGE_SEL_W, CAPTURE_FIFO_DEPTH_LOG2, CAPTURE_SYNC_STAGES).
//   - Edge-select encoding capture_edge_e: NONE=0, RISE=1, FALL=2, BOTH=3.
//   - edge_hits(): decides whether a detected rise/fall matches a selection.
package timer_capture_pkg;

  localparam int TIMER_DATA_W            = 32;
  localparam int TIMER_VALUE_W           = 2 * TIMER_DATA_W;

  localparam int CAPTURE_FIFO_DEPTH_LOG2 = 2;
  localparam int CAPTURE_SYNC_STAGES     = 2;
  localparam int CAPTURE_DATA_W          = TIMER_VALUE_W;
  localparam int CAPTURE_LEVEL_W         = CAPTURE_FIFO_DEPTH_LOG2 + 1;
  localparam int CAPTURE_EDGE_SEL_W      = 2;

  typedef enum logic [CAPTURE_EDGE_SEL_W-1:0] {
    CAPTURE_EDGE_NONE = 2'd0,
    CAPTURE_EDGE_RISE = 2'd1,
    CAPTURE_EDGE_FALL = 2'd2,
    CAPTURE_EDGE_BOTH = 2'd3
  } capture_edge_e;

  // True when the observed transition is one the selection asks for.
  function automatic logic edge_hits(capture_edge_e sel, logic rise, logic fall);
    logic want_rise;
    logic want_fall;
    want_rise = (sel == CAPTURE_EDGE_RISE) || (sel == CAPTURE_EDGE_BOTH);
    want_fall = (sel == CAPTURE_EDGE_FALL) || (sel == CAPTURE_EDGE_BOTH);
    return (rise && want_rise) || (fall && want_fall);
  endfunction

endpackage

// File: rtl/timer_capture_if.sv
// Software-facing register bus of the timer input-capture unit.
//
// Parameters: DATA_W (timestamp is 2*DATA_W bits), FIFO_DEPTH_LOG2.
// Signals:
//   CAPTURE_ENABLE, CAPTURE_EDGE_SEL, CAPTURE_POP, CAPTURE_OVF_CLR,
//   CAPTURE_INTERRUPT_ENABLE                       -> driven by software (master)
//   CAPTURE_DATA, CAPTURE_EMPTY, CAPTURE_FULL, CAPTURE_LEVEL,
//   CAPTURE_OVERFLOW, CAPTURE_INTERRUPT            -> driven by the unit (slave)
//
// Handshake: the only transfer on this bus is the read of a timestamp.
// CAPTURE_EMPTY=0 is the "valid" for CAPTURE_DATA; the unit is always ready,
// so an entry is consumed on a rising clk edge where CAPTURE_POP=1 and
// CAPTURE_EMPTY=0. A pop strobe while CAPTURE_EMPTY=1 is ignored.
interface timer_capture_if
  import timer_capture_pkg::*;
#(
  parameter int DATA_W          = TIMER_DATA_W,
  parameter int FIFO_DEPTH_LOG2 = CAPTURE_FIFO_DEPTH_LOG2
);

  logic                          CAPTURE_ENABLE;
  logic [CAPTURE_EDGE_SEL_W-1:0] CAPTURE_EDGE_SEL;
  logic                          CAPTURE_POP;
  logic                          CAPTURE_OVF_CLR;
  logic                          CAPTURE_INTERRUPT_ENABLE;
  logic [2*DATA_W-1:0]           CAPTURE_DATA;
  logic                          CAPTURE_EMPTY;
  logic                          CAPTURE_FULL;
  logic [FIFO_DEPTH_LOG2:0]      CAPTURE_LEVEL;
  logic                          CAPTURE_OVERFLOW;
  logic                          CAPTURE_INTERRUPT;

  modport master (
    output CAPTURE_ENABLE,
    output CAPTURE_EDGE_SEL,
    output CAPTURE_POP,
    output CAPTURE_OVF_CLR,
    output CAPTURE_INTERRUPT_ENABLE,
    input  CAPTURE_DATA,
    input  CAPTURE_EMPTY,
    input  CAPTURE_FULL,
    input  CAPTURE_LEVEL,
    input  CAPTURE_OVERFLOW,
    input  CAPTURE_INTERRUPT
  );

  modport slave (
    input  CAPTURE_ENABLE,
    input  CAPTURE_EDGE_SEL,
    input  CAPTURE_POP,
    input  CAPTURE_OVF_CLR,
    input  CAPTURE_INTERRUPT_ENABLE,
    output CAPTURE_DATA,
    output CAPTURE_EMPTY,
    output CAPTURE_FULL,
    output CAPTURE_LEVEL,
    output CAPTURE_OVERFLOW,
    output CAPTURE_INTERRUPT
  );

endinterface

// File: rtl/timer_capture_fifo.sv
// Show-ahead circular FIFO holding captured timestamps.
//
// Parameters: WIDTH (entry width), DEPTH_LOG2 (depth = 2**DEPTH_LOG2, >= 1).
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   push/push_data write request and data
//   pop            discard head entry (ignored when empty)
//   rd_data        head entry; when empty, the last popped (or reset) value
//   empty/full     status from the extra-MSB pointer compare
//   level          number of stored entries
//   ovf_pulse      high in a cycle where a push is dropped because full
module timer_capture_fifo
  import timer_capture_pkg::*;
#(
  parameter int WIDTH      = CAPTURE_DATA_W,
  parameter int DEPTH_LOG2 = CAPTURE_LEVEL_W - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf_pulse
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    last_q;
  logic [DEPTH_LOG2:0] wr_ptr_q;
  logic [DEPTH_LOG2:0] rd_ptr_q;
  logic                do_pop;
  logic                do_push;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign ovf_pulse = push && full && !do_pop;

  // While empty the head slot may hold stale data from an earlier lap, so the
  // last popped value is kept separately and shown instead.
  assign rd_data = empty ? last_q : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        last_q   <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_capture.sv
// Timer input-capture unit: timestamps edges of an asynchronous input with
// the live 64-bit timer count and queues the stamps for software.
//
// Parameters: DATA_W (timestamp is 2*DATA_W bits), FIFO_DEPTH_LOG2,
//             SYNC_STAGES (>= 2).
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   TIMER_VALUE  live timer count to be sampled
//   CAPTURE_IN   external asynchronous event input
//   regs         software register bus (timer_capture_if.slave)
//
// Build option: define TIMER_CAPTURE_FILTER_EN to insert a glitch filter
// (FILTER_LEN=4 cycles of stability) between the synchronizer and the edge
// detector. Without it, edges are taken straight from the synchronizer.
module timer_capture
  import timer_capture_pkg::*;
#(
  parameter int DATA_W          = TIMER_DATA_W,
  parameter int FIFO_DEPTH_LOG2 = CAPTURE_FIFO_DEPTH_LOG2,
  parameter int SYNC_STAGES     = CAPTURE_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DATA_W-1:0] TIMER_VALUE,
  input  logic                CAPTURE_IN,
  timer_capture_if.slave      regs
);

  localparam int TS_W = 2 * DATA_W;

  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     synced;
  logic                     det_level;
  logic                     prev_q;
  logic                     rise;
  logic                     fall;
  logic                     capture_event;
  logic [TS_W-1:0]          fifo_data;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic [FIFO_DEPTH_LOG2:0] fifo_level;
  logic                     fifo_ovf;
  logic                     ovf_q;
  logic                     irq_q;

  // Synchronizer runs regardless of enable so the chain is always settled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], CAPTURE_IN};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef TIMER_CAPTURE_FILTER_EN
  localparam int FILTER_LEN = 4;
  localparam int FCNT_W     = $clog2(FILTER_LEN);

  logic              filt_q;
  logic [FCNT_W-1:0] fcnt_q;

  // fcnt_q counts consecutive cycles where the synchronized input disagrees
  // with the filtered level; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (synced == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
      filt_q <= synced;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign det_level = filt_q;
`else
  assign det_level = synced;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= det_level;
    end
  end

  assign rise = det_level && !prev_q;
  assign fall = !det_level && prev_q;

  // TIMER_VALUE in the event cycle becomes the stored stamp at the next edge.
  assign capture_event = regs.CAPTURE_ENABLE &&
                         edge_hits(capture_edge_e'(regs.CAPTURE_EDGE_SEL), rise, fall);

  timer_capture_fifo #(
    .WIDTH      (TS_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture_event),
    .push_data (TIMER_VALUE),
    .pop       (regs.CAPTURE_POP),
    .rd_data   (fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level),
    .ovf_pulse (fifo_ovf)
  );

  // Overflow is sticky; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (fifo_ovf) begin
        ovf_q <= 1'b1;
      end else if (regs.CAPTURE_OVF_CLR) begin
        ovf_q <= 1'b0;
      end
      irq_q <= regs.CAPTURE_INTERRUPT_ENABLE && !fifo_empty;
    end
  end

  assign regs.CAPTURE_DATA      = fifo_data;
  assign regs.CAPTURE_EMPTY     = fifo_empty;
  assign regs.CAPTURE_FULL      = fifo_full;
  assign regs.CAPTURE_LEVEL     = fifo_level;
  assign regs.CAPTURE_OVERFLOW  = ovf_q;
  assign regs.CAPTURE_INTERRUPT = irq_q;

endmodule

// File: tb/tb_timer_capture.sv
// Self-checking bench for timer_capture: reset state, directed timestamp and
// FIFO corner sequences, a table of multi-cycle register scenarios, and a
// randomized run against a behavioural model of the capture rules.
module tb_timer_capture;
  import timer_capture_pkg::*;

  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 4;
  localparam int SYNC       = 2;
`ifdef TIMER_CAPTURE_FILTER_EN
  localparam int LAT        = SYNC + 4;
`else
  localparam int LAT        = SYNC;
`endif
  localparam int NRAND      = 1500;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic [63:0] timer_value;
  logic        capture_in;

  timer_capture_if #(.DATA_W(DATA_W), .FIFO_DEPTH_LOG2(DEPTH_LOG2)) bus ();

  timer_capture #(
    .DATA_W          (DATA_W),
    .FIFO_DEPTH_LOG2 (DEPTH_LOG2),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .TIMER_VALUE (timer_value),
    .CAPTURE_IN  (capture_in),
    .regs        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got no completion, required finish within 5ms");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string name, input int lvl, input bit ovf, input bit irq);
    check({name, " level"}, 64'(bus.CAPTURE_LEVEL), 64'(lvl));
    check({name, " empty"}, 64'(bus.CAPTURE_EMPTY), 64'(lvl == 0));
    check({name, " full"},  64'(bus.CAPTURE_FULL),  64'(lvl == DEPTH));
    check({name, " overflow"},  64'(bus.CAPTURE_OVERFLOW),  64'(ovf));
    check({name, " interrupt"}, 64'(bus.CAPTURE_INTERRUPT), 64'(irq));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int inc = 1);
    @(posedge clk);
    #1;
    timer_value = timer_value + 64'(inc);
  endtask

  task automatic set_ctl(input bit en, input bit [1:0] sel, input bit pop,
                         input bit clr, input bit ie);
    bus.CAPTURE_ENABLE           = en;
    bus.CAPTURE_EDGE_SEL         = sel;
    bus.CAPTURE_POP              = pop;
    bus.CAPTURE_OVF_CLR          = clr;
    bus.CAPTURE_INTERRUPT_ENABLE = ie;
  endtask

  // Leaves the bench in cycle 0 after release, TIMER_VALUE = tv0.
  task automatic apply_reset(input logic [63:0] tv0);
    rst = 1'b0;
    capture_in = 1'b0;
    set_ctl(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    timer_value = tv0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic pop_once();
    bus.CAPTURE_POP = 1'b1;
    tick();
    bus.CAPTURE_POP = 1'b0;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    bit       cin;
    bit       en;
    bit [1:0] sel;
    bit       pop;
    bit       clr;
    bit       ie;
    int       cycles;
    int       exp_level;
    bit       exp_ovf;
    bit       exp_int;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(bit cin, bit en, bit [1:0] sel, bit pop, bit clr, bit ie,
                                  int cycles, int exp_level, bit exp_ovf, bit exp_int);
    vec_t v;
    v.cin = cin; v.en = en; v.sel = sel; v.pop = pop; v.clr = clr; v.ie = ie;
    v.cycles = cycles; v.exp_level = exp_level; v.exp_ovf = exp_ovf; v.exp_int = exp_int;
    vecs.push_back(v);
  endfunction

  // ---------------- reference model ----------------
  bit          in_h  [NRAND];
  bit          lvl_h [NRAND];
  logic [63:0] m_q[$];
  logic [63:0] m_last;
  bit          m_ovf;
  bit          m_int;

  // The synchronized input in cycle c is whatever was driven SYNC cycles earlier.
  function automatic bit synced_at(int c);
    if (c < SYNC) return 1'b0;
    return in_h[c - SYNC];
  endfunction

  function automatic bit level_at(int c);
    bit prev;
    prev = (c > 0) ? lvl_h[c-1] : 1'b0;
`ifdef TIMER_CAPTURE_FILTER_EN
    // The filtered level follows the input once it has held for 4 cycles.
    if (synced_at(c-1) == synced_at(c-2) && synced_at(c-2) == synced_at(c-3) &&
        synced_at(c-3) == synced_at(c-4))
      return synced_at(c-1);
    return prev;
`else
    return synced_at(c);
`endif
  endfunction

  // ---------------- test body ----------------
  initial begin
    logic [63:0] t0;
    logic [63:0] d0;
    logic [63:0] stamps[$];
    int waited;
    bit fast;

    // Reset held low: all outputs at reset values.
    apply_reset(64'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("reset data", bus.CAPTURE_DATA, 64'd0);
    check_status("reset", 0, 1'b0, 1'b0);
    rst = 1'b1;
    set_ctl(1'b1, CAPTURE_EDGE_BOTH, 1'b0, 1'b0, 1'b1);
    repeat (10) tick();
    check_status("idle after release", 0, 1'b0, 1'b0);

    // Single rising edge at cycle 10, timer counting from 100.
    apply_reset(64'd100);
    set_ctl(1'b1, CAPTURE_EDGE_RISE, 1'b0, 1'b0, 1'b1);
    repeat (10) tick();
    capture_in = 1'b1;
    t0 = timer_value;
    waited = 0;
    for (int k = 0; k < 20 && bus.CAPTURE_EMPTY; k++) begin
      tick();
      waited++;
    end
    check("capture latency", 64'(waited), 64'(LAT + 1));
    check("single stamp", bus.CAPTURE_DATA, 64'd110 + 64'(LAT));
    check("single stamp vs t0", bus.CAPTURE_DATA, t0 + 64'(LAT));
    check_status("single", 1, 1'b0, 1'b0);
    tick();
    check("single irq next cycle", 64'(bus.CAPTURE_INTERRUPT), 64'd1);

    // Both edges, five pulses, no pops: first four stamps kept, overflow set.
    apply_reset(64'd1000);
    set_ctl(1'b1, CAPTURE_EDGE_BOTH, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    exp_q.delete();
    for (int p = 0; p < 5; p++) begin
      capture_in = 1'b1;
      if (exp_q.size() < DEPTH) exp_q.push_back(timer_value + 64'(LAT));
      repeat (8) tick();
      capture_in = 1'b0;
      if (exp_q.size() < DEPTH) exp_q.push_back(timer_value + 64'(LAT));
      repeat (8) tick();
    end
    check_status("five pulses", DEPTH, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("fifo order %0d", i), bus.CAPTURE_DATA, exp_q.pop_front());
      pop_once();
    end
    check_status("drained", 0, 1'b1, 1'b1);
    tick();
    check_status("drained irq low", 0, 1'b1, 1'b0);
    bus.CAPTURE_OVF_CLR = 1'b1;
    tick();
    bus.CAPTURE_OVF_CLR = 1'b0;
    check_status("overflow cleared", 0, 1'b0, 1'b0);

    // Full FIFO, push and pop in the same cycle.
    apply_reset(64'd5000);
    set_ctl(1'b1, CAPTURE_EDGE_BOTH, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    stamps.delete();
    for (int p = 0; p < 2; p++) begin
      capture_in = 1'b1;
      stamps.push_back(timer_value + 64'(LAT));
      repeat (8) tick();
      capture_in = 1'b0;
      stamps.push_back(timer_value + 64'(LAT));
      repeat (8) tick();
    end
    check("pre full", 64'(bus.CAPTURE_FULL), 64'd1);
    capture_in = 1'b1;
    t0 = timer_value;
    repeat (LAT) tick();
    pop_once();
    check_status("push+pop on full", DEPTH, 1'b0, 1'b0);
    check("push+pop head", bus.CAPTURE_DATA, stamps[1]);
    repeat (3) pop_once();
    check("push+pop tail", bus.CAPTURE_DATA, t0 + 64'(LAT));
    pop_once();
    check("push+pop last popped", bus.CAPTURE_DATA, t0 + 64'(LAT));

    // Short-pulse behaviour.
    apply_reset(64'd7000);
    set_ctl(1'b1, CAPTURE_EDGE_BOTH, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
`ifdef TIMER_CAPTURE_FILTER_EN
    capture_in = 1'b1;
    repeat (2) tick();
    capture_in = 1'b0;
    repeat (12) tick();
    check("glitch rejected", 64'(bus.CAPTURE_LEVEL), 64'd0);
    capture_in = 1'b1;
    t0 = timer_value;
    repeat (6) tick();
    capture_in = 1'b0;
    repeat (12) tick();
    check("6-cycle pulse captures", 64'(bus.CAPTURE_LEVEL), 64'd2);
    d0 = bus.CAPTURE_DATA;
    check("6-cycle pulse rise stamp", d0, t0 + 64'(LAT));
    pop_once();
    check("6-cycle pulse spacing", bus.CAPTURE_DATA - d0, 64'd6);
`else
    capture_in = 1'b1;
    t0 = timer_value;
    tick();
    capture_in = 1'b0;
    repeat (8) tick();
    check("1-cycle pulse captures", 64'(bus.CAPTURE_LEVEL), 64'd2);
    d0 = bus.CAPTURE_DATA;
    check("1-cycle pulse rise stamp", d0, t0 + 64'(LAT));
    pop_once();
    check("1-cycle pulse spacing", bus.CAPTURE_DATA - d0, 64'd1);
`endif

    // Table: enable/select gating, pop on empty, fill, overflow, interrupt mask.
    //       cin en sel pop clr ie cyc lvl ovf int
    add_vec(0, 0, 3, 0, 0, 1, 10, 0, 0, 0);
    add_vec(1, 0, 3, 0, 0, 1, 10, 0, 0, 0);
    add_vec(0, 0, 3, 0, 0, 1, 10, 0, 0, 0);
    add_vec(1, 1, 0, 0, 0, 1, 10, 0, 0, 0);
    add_vec(0, 1, 0, 0, 0, 1, 10, 0, 0, 0);
    add_vec(0, 1, 0, 1, 0, 1,  3, 0, 0, 0);
    add_vec(1, 1, 2, 0, 0, 1, 10, 0, 0, 0);
    add_vec(0, 1, 2, 0, 0, 1, 10, 1, 0, 1);
    add_vec(1, 1, 1, 0, 0, 1, 10, 2, 0, 1);
    add_vec(0, 1, 1, 0, 0, 1, 10, 2, 0, 1);
    add_vec(1, 1, 3, 0, 0, 1, 10, 3, 0, 1);
    add_vec(0, 1, 3, 0, 0, 1, 10, 4, 0, 1);
    add_vec(1, 1, 3, 0, 0, 1, 10, 4, 1, 1);
    add_vec(1, 1, 3, 0, 1, 1,  1, 4, 0, 1);
    add_vec(1, 1, 3, 1, 0, 1,  4, 0, 0, 1);
    add_vec(1, 1, 3, 0, 0, 1,  2, 0, 0, 0);
    add_vec(0, 1, 3, 0, 0, 0, 10, 1, 0, 0);
    add_vec(0, 1, 3, 0, 0, 1,  2, 1, 0, 1);
    add_vec(0, 1, 3, 1, 0, 1,  1, 0, 0, 1);
    add_vec(0, 1, 3, 0, 0, 1,  1, 0, 0, 0);
    apply_reset(64'd0);
    foreach (vecs[i]) begin
      capture_in = vecs[i].cin;
      set_ctl(vecs[i].en, vecs[i].sel, vecs[i].pop, vecs[i].clr, vecs[i].ie);
      repeat (vecs[i].cycles) tick();
      check_status($sformatf("vec %0d", i), vecs[i].exp_level, vecs[i].exp_ovf,
                   vecs[i].exp_int);
    end

    // Randomized run against the model, timer starting just below wrap.
    apply_reset(64'hFFFF_FFFF_FFFF_FFC0);
    bus.CAPTURE_INTERRUPT_ENABLE = 1'b1;
    bus.CAPTURE_EDGE_SEL = CAPTURE_EDGE_BOTH;
    m_q.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    m_int  = 1'b0;
    fast   = 1'b0;
    for (int c = 0; c < NRAND; c++) begin
      bit lvl;
      bit prev;
      bit ev;
      bit do_pop;
      if (c % 100 == 0) fast = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 99) < (fast ? 50 : 6)) capture_in = ~capture_in;
      bus.CAPTURE_ENABLE  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) bus.CAPTURE_EDGE_SEL = 2'($urandom_range(0, 3));
      bus.CAPTURE_POP     = ($urandom_range(0, 99) < 35);
      bus.CAPTURE_OVF_CLR = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 49) == 0)
        bus.CAPTURE_INTERRUPT_ENABLE = ~bus.CAPTURE_INTERRUPT_ENABLE;

      in_h[c]  = capture_in;
      lvl      = level_at(c);
      lvl_h[c] = lvl;
      prev     = (c > 0) ? lvl_h[c-1] : 1'b0;
      ev = bus.CAPTURE_ENABLE &&
           ((lvl && !prev && bus.CAPTURE_EDGE_SEL[0]) ||
            (!lvl && prev && bus.CAPTURE_EDGE_SEL[1]));

      m_int  = bus.CAPTURE_INTERRUPT_ENABLE && (m_q.size() != 0);
      do_pop = bus.CAPTURE_POP && (m_q.size() != 0);
      if (ev && m_q.size() == DEPTH && !do_pop) begin
        m_ovf = 1'b1;
      end else begin
        if (bus.CAPTURE_OVF_CLR) m_ovf = 1'b0;
      end
      if (do_pop) m_last = m_q.pop_front();
      if (ev && m_q.size() < DEPTH) m_q.push_back(timer_value);

      tick(($urandom_range(0, 63) == 0) ? int'($urandom_range(1000, 100000)) : 1);

      check_status($sformatf("rand %0d", c), m_q.size(), m_ovf, m_int);
      check($sformatf("rand %0d data", c), bus.CAPTURE_DATA,
            (m_q.size() != 0) ? m_q[0] : m_last);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
